// File: rtl/sb_split_slave.sv
// sb_split_slave -- SB bus memory slave with burst splitting
//
// Purpose:
//   Drop-in memory slave behind the SB decoder/mux. It holds an inferred
//   word memory of 2**MEM_ADDR_WIDTH words and serves single and burst
//   reads/writes. When the build macro SB_SLAVE_SPLIT_EN is defined, long
//   unlocked bursts are cut after SPLIT_BEATS beats. The remaining work is
//   parked in a per-master context, and the master is released through
//   sb_split RELEASE_DELAY cycles after the SPLIT response ends. With the
//   macro undefined, bursts always run to completion and sb_split is 0.
//
// Ports:
//   sb_clk       in   clock
//   sb_reset     in   synchronous reset, active-high
//   sb_sel       in   slave select
//   sb_addr      in   byte/word address; word index = low MEM_ADDR_WIDTH bits
//   sb_write     in   1 = write, 0 = read
//   sb_trans     in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   sb_size      in   burst code (000/001/010=1, 011=2, 100=4 ... 111=32)
//   sb_wdata     in   write data
//   sb_master    in   current master id
//   sb_mastlock  in   locked transfer, never split
//   sb_ready     out  beat accepted / read data valid
//   sb_resp      out  0=none, OKAY=1, ERROR=2, SPLIT=3
//   sb_rdata     out  registered read data
//   sb_split     out  one-cycle release pulse per master
//
// Build option: SB_SLAVE_SPLIT_EN enables split, context table and timers.

module sb_split_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int NUM_MASTERS    = 2,
    parameter int MID_WIDTH      = 1,
    parameter int SPLIT_BEATS    = 8,
    parameter int RELEASE_DELAY  = 4
) (
    input  logic                   sb_clk,
    input  logic                   sb_reset,
    input  logic                   sb_sel,
    input  logic [ADDR_WIDTH-1:0]  sb_addr,
    input  logic                   sb_write,
    input  logic [1:0]             sb_trans,
    input  logic [2:0]             sb_size,
    input  logic [DATA_WIDTH-1:0]  sb_wdata,
    input  logic [MID_WIDTH-1:0]   sb_master,
    input  logic                   sb_mastlock,
    output logic                   sb_ready,
    output logic [1:0]             sb_resp,
    output logic [DATA_WIDTH-1:0]  sb_rdata,
    output logic [NUM_MASTERS-1:0] sb_split
);

    localparam int MAW   = MEM_ADDR_WIDTH;
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int SUM_W = MEM_ADDR_WIDTH + 7;

    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_OKAY  = 2'd1;
    localparam logic [1:0] RESP_ERROR = 2'd2;
`ifdef SB_SLAVE_SPLIT_EN
    localparam logic [1:0] RESP_SPLIT = 2'd3;
    localparam int         TW         = $clog2(RELEASE_DELAY) + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_XFER,
        S_ERR1,
        S_ERR2,
        S_SPL1,
        S_SPL2
    } state_t;

    function automatic logic [5:0] burst_len(input logic [2:0] size);
        case (size)
            3'b011:  burst_len = 6'd2;
            3'b100:  burst_len = 6'd4;
            3'b101:  burst_len = 6'd8;
            3'b110:  burst_len = 6'd16;
            3'b111:  burst_len = 6'd32;
            default: burst_len = 6'd1;
        endcase
    endfunction

    // Transfer state
    state_t                  state_q, state_d;
    logic [MAW-1:0]          addr_q, addr_d;
    logic                    dir_q, dir_d;
    logic [5:0]              rem_q, rem_d;
    logic                    first_q, first_d;

    // Memory and read register
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    mem_we;
    logic                    rd_load;

    // Address decode for a new NONSEQ
    logic [MAW-1:0]          word_addr;
    logic                    upper_nz;
    logic [5:0]              eff_len;
    logic [SUM_W-1:0]        end_sum;
    logic                    addr_err;

`ifdef SB_SLAVE_SPLIT_EN
    logic [MID_WIDTH-1:0]    mid_q, mid_d;
    logic [5:0]              tcnt_q, tcnt_d;

    logic [NUM_MASTERS-1:0]  ctx_vld_q, ctx_vld_d;
    logic [MAW-1:0]          ctx_addr_q [NUM_MASTERS];
    logic [5:0]              ctx_rem_q  [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]  ctx_dir_q;
    logic                    ctx_save;

    logic [NUM_MASTERS-1:0]  act_q;
    logic [TW-1:0]           tmr_q [NUM_MASTERS];
    logic                    tmr_load;

    logic                    hit_vld;
    logic [MAW-1:0]          hit_addr;
    logic [5:0]              hit_rem;
    logic                    hit_dir;
    logic                    resume;
`else
    logic                    unused_cfg;
    assign unused_cfg = ^{sb_mastlock, sb_master, 32'(SPLIT_BEATS), 32'(RELEASE_DELAY)};
`endif

    assign word_addr = sb_addr[MAW-1:0];
    assign upper_nz  = |sb_addr[ADDR_WIDTH-1:MAW];

`ifdef SB_SLAVE_SPLIT_EN
    // Context lookup for the master presenting the NONSEQ.
    always_comb begin
        hit_vld  = 1'b0;
        hit_addr = '0;
        hit_rem  = '0;
        hit_dir  = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (sb_master == MID_WIDTH'(m)) begin
                hit_vld  = ctx_vld_q[m];
                hit_addr = ctx_addr_q[m];
                hit_rem  = ctx_rem_q[m];
                hit_dir  = ctx_dir_q[m];
            end
        end
    end

    // A context resumes only if the master comes back to the exact next
    // address in the same direction; anything else is a fresh transfer.
    assign resume  = hit_vld && (hit_addr == word_addr) && (hit_dir == sb_write);
    assign eff_len = resume ? hit_rem : burst_len(sb_size);
`else
    assign eff_len = burst_len(sb_size);
`endif

    // The whole burst must fit below the top of memory; no wrap-around.
    assign end_sum  = SUM_W'(word_addr) + SUM_W'(eff_len);
    assign addr_err = upper_nz || (end_sum > SUM_W'(DEPTH));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        first_d  = first_q;
        mem_we   = 1'b0;
        rd_load  = 1'b0;
        sb_ready = 1'b0;
        sb_resp  = RESP_NONE;
`ifdef SB_SLAVE_SPLIT_EN
        mid_d     = mid_q;
        tcnt_d    = tcnt_q;
        ctx_vld_d = ctx_vld_q;
        ctx_save  = 1'b0;
        tmr_load  = 1'b0;
`endif

        if (sb_reset) begin
            // Outputs held low; registers are cleared by the state process.
        end else if (!sb_sel) begin
            // Losing select mid-transfer abandons it without saving context.
            if (state_q == S_XFER) begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    sb_ready = 1'b1;
                    if (sb_trans == TR_NONSEQ) begin
                        addr_d  = word_addr;
                        dir_d   = sb_write;
                        rem_d   = eff_len;
                        first_d = 1'b1;
`ifdef SB_SLAVE_SPLIT_EN
                        mid_d   = sb_master;
                        tcnt_d  = '0;
`endif
                        if (addr_err) begin
                            state_d = S_ERR1;
                        end else begin
`ifdef SB_SLAVE_SPLIT_EN
                            // Whether resumed or discarded, the context is consumed.
                            for (int m = 0; m < NUM_MASTERS; m++) begin
                                if (sb_master == MID_WIDTH'(m)) begin
                                    ctx_vld_d[m] = 1'b0;
                                end
                            end
`endif
                            state_d = sb_write ? S_XFER : S_RD_WAIT;
                        end
                    end
                end

                S_RD_WAIT: begin
                    // Memory latency: prefetch the first word into sb_rdata.
                    rd_load = 1'b1;
                    state_d = S_XFER;
                end

                S_XFER: begin
                    sb_ready = 1'b1;
                    sb_resp  = RESP_OKAY;
                    if (first_q || sb_trans == TR_SEQ) begin
                        first_d = 1'b0;
                        mem_we  = dir_q;
                        rd_load = !dir_q;
                        addr_d  = addr_q + MAW'(1);
                        rem_d   = rem_q - 6'd1;
`ifdef SB_SLAVE_SPLIT_EN
                        tcnt_d  = tcnt_q + 6'd1;
`endif
                        if (rem_d == 6'd0) begin
                            state_d = S_IDLE;
                        end
`ifdef SB_SLAVE_SPLIT_EN
                        else if (tcnt_d == 6'(SPLIT_BEATS) && !sb_mastlock) begin
                            ctx_save = 1'b1;
                            for (int m = 0; m < NUM_MASTERS; m++) begin
                                if (mid_q == MID_WIDTH'(m)) begin
                                    ctx_vld_d[m] = 1'b1;
                                end
                            end
                            state_d = S_SPL1;
                        end
`endif
                    end else if (sb_trans != TR_BUSY) begin
                        // IDLE or NONSEQ before the last beat ends the burst early.
                        state_d = S_IDLE;
                    end
                end

                S_ERR1: begin
                    sb_resp = RESP_ERROR;
                    state_d = S_ERR2;
                end

                S_ERR2: begin
                    sb_ready = 1'b1;
                    sb_resp  = RESP_ERROR;
                    state_d  = S_IDLE;
                end

`ifdef SB_SLAVE_SPLIT_EN
                S_SPL1: begin
                    sb_resp = RESP_SPLIT;
                    state_d = S_SPL2;
                end

                S_SPL2: begin
                    sb_ready = 1'b1;
                    sb_resp  = RESP_SPLIT;
                    tmr_load = 1'b1;
                    state_d  = S_IDLE;
                end
`endif

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sb_clk) begin
        if (sb_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sb_clk) begin
        addr_q  <= addr_d;
        dir_q   <= dir_d;
        rem_q   <= rem_d;
        first_q <= first_d;
`ifdef SB_SLAVE_SPLIT_EN
        mid_q   <= mid_d;
        tcnt_q  <= tcnt_d;
`endif
    end

    // mem_we is never raised while sb_reset is high, so a reset edge
    // mid-burst stops all further writes.
    always_ff @(posedge sb_clk) begin
        if (mem_we) begin
            mem[addr_q] <= sb_wdata;
        end
    end

    // Read data always tracks the next beat address, so it is already
    // valid when the beat is presented with sb_ready high.
    always_ff @(posedge sb_clk) begin
        if (sb_reset) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= mem[addr_d];
        end
    end

    assign sb_rdata = rdata_q;

`ifdef SB_SLAVE_SPLIT_EN
    always_ff @(posedge sb_clk) begin
        if (sb_reset) begin
            ctx_vld_q <= '0;
        end else begin
            ctx_vld_q <= ctx_vld_d;
        end
    end

    always_ff @(posedge sb_clk) begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (ctx_save && mid_q == MID_WIDTH'(m)) begin
                ctx_addr_q[m] <= addr_d;
                ctx_rem_q[m]  <= rem_d;
                ctx_dir_q[m]  <= dir_q;
            end
        end
    end

    // Timer loads RELEASE_DELAY-1 on leaving SPL2 so the pulse lands
    // RELEASE_DELAY cycles after the SPL2 cycle. A reload restarts it.
    always_ff @(posedge sb_clk) begin
        if (sb_reset) begin
            act_q <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                tmr_q[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (tmr_load && mid_q == MID_WIDTH'(m)) begin
                    act_q[m] <= 1'b1;
                    tmr_q[m] <= TW'(RELEASE_DELAY - 1);
                end else if (act_q[m]) begin
                    if (tmr_q[m] == '0) begin
                        act_q[m] <= 1'b0;
                    end else begin
                        tmr_q[m] <= tmr_q[m] - TW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        sb_split = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            sb_split[m] = act_q[m] && (tmr_q[m] == '0);
        end
    end
`else
    assign sb_split = '0;
`endif

endmodule

// File: tb/tb_sb_split_slave.sv
// Directed bench for sb_split_slave (default parameters). The split
// scenarios expect SPLIT behaviour when SB_SLAVE_SPLIT_EN is defined and
// full-length bursts otherwise.

module tb_sb_split_slave;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [0:0]  master;
    logic        lock;
    logic        ready;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  split;

    int vectors;
    int miscompares;

    sb_split_slave dut (
        .sb_clk      (clk),
        .sb_reset    (rst),
        .sb_sel      (sel),
        .sb_addr     (addr),
        .sb_write    (wr),
        .sb_trans    (trans),
        .sb_size     (size),
        .sb_wdata    (wdata),
        .sb_master   (master),
        .sb_mastlock (lock),
        .sb_ready    (ready),
        .sb_resp     (resp),
        .sb_rdata    (rdata),
        .sb_split    (split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_chk(input string tag);
        trans = 2'd0;
        #1;
        chk($sformatf("%s idle rdy", tag), 32'(ready), 1);
        chk($sformatf("%s idle resp", tag), 32'(resp), 0);
    endtask

    // Address phase; for reads also steps through the wait cycle.
    task automatic nonseq(input logic [31:0] a, input logic w, input logic [2:0] sz,
                          input logic m, input logic l, input string tag);
        sel = 1'b1; trans = 2'd2; addr = a; wr = w; size = sz; master = m; lock = l;
        #1;
        chk($sformatf("%s ns rdy", tag), 32'(ready), 1);
        cyc();
        if (!w) begin
            trans = 2'd3;
            #1;
            chk($sformatf("%s wait rdy", tag), 32'(ready), 0);
            chk($sformatf("%s wait resp", tag), 32'(resp), 0);
            cyc();
        end
    endtask

    task automatic wbeat(input logic [31:0] d, input string tag);
        trans = 2'd3; wdata = d;
        #1;
        chk($sformatf("%s wbeat rdy", tag), 32'(ready), 1);
        chk($sformatf("%s wbeat resp", tag), 32'(resp), 1);
        cyc();
    endtask

    task automatic rbeat(input logic [31:0] e, input string tag);
        trans = 2'd3;
        #1;
        chk($sformatf("%s rbeat rdy", tag), 32'(ready), 1);
        chk($sformatf("%s rbeat resp", tag), 32'(resp), 1);
        chk($sformatf("%s rbeat data", tag), rdata, e);
        cyc();
    endtask

    task automatic wburst(input logic [31:0] a, input logic [2:0] sz, input int n,
                          input logic [31:0] base, input logic m, input logic l, input string tag);
        nonseq(a, 1'b1, sz, m, l, tag);
        for (int i = 0; i < n; i++) wbeat(base + 32'(i), tag);
        idle_chk(tag);
    endtask

    task automatic rburst(input logic [31:0] a, input logic [2:0] sz, input int n,
                          input logic [31:0] base, input string tag);
        nonseq(a, 1'b0, sz, 1'b0, 1'b0, tag);
        for (int i = 0; i < n; i++) rbeat(base + 32'(i), $sformatf("%s[%0d]", tag, i));
        idle_chk(tag);
    endtask

    task automatic err_seq(input logic [31:0] a, input logic [2:0] sz, input string tag);
        sel = 1'b1; trans = 2'd2; addr = a; wr = 1'b1; size = sz; master = 1'b0; lock = 1'b0;
        #1;
        chk($sformatf("%s ns rdy", tag), 32'(ready), 1);
        cyc();
        trans = 2'd3; wdata = 32'h1111_1111;
        #1;
        chk($sformatf("%s err1 rdy", tag), 32'(ready), 0);
        chk($sformatf("%s err1 resp", tag), 32'(resp), 2);
        cyc();
        #1;
        chk($sformatf("%s err2 rdy", tag), 32'(ready), 1);
        chk($sformatf("%s err2 resp", tag), 32'(resp), 2);
        cyc();
        idle_chk(tag);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; sel = 1'b1; addr = '0; wr = 1'b0; trans = 2'd0;
        size = 3'd0; wdata = '0; master = 1'b0; lock = 1'b0;

        // Reset state
        @(negedge clk);
        cyc();
        #1;
        chk("reset rdy", 32'(ready), 0);
        chk("reset resp", 32'(resp), 0);
        chk("reset rdata", rdata, 0);
        chk("reset split", 32'(split), 0);
        rst = 1'b0;
        cyc();
        idle_chk("post reset");

        // Deselect in IDLE: outputs low, NONSEQ ignored
        sel = 1'b0; trans = 2'd2; addr = 32'h800; wr = 1'b1;
        #1;
        chk("desel rdy", 32'(ready), 0);
        chk("desel resp", 32'(resp), 0);
        cyc();
        sel = 1'b1;
        idle_chk("after desel");

        // Single write then single read at 0x10
        wburst(32'h10, 3'b000, 1, 32'hDEADBEEF, 1'b0, 1'b0, "single wr");
        rburst(32'h10, 3'b000, 1, 32'hDEADBEEF, "single rd");

        // 4-beat burst at 0x20, data 1..4, no split
        wburst(32'h20, 3'b100, 4, 32'd1, 1'b0, 1'b0, "burst4 wr");
        rburst(32'h20, 3'b100, 4, 32'd1, "burst4 rd");
        chk("burst4 split", 32'(split), 0);

        // Deselect during XFER abandons the burst
        nonseq(32'h30, 1'b1, 3'b100, 1'b0, 1'b0, "xfer desel");
        wbeat(32'h33, "xfer desel");
        sel = 1'b0; trans = 2'd3;
        #1;
        chk("xfer desel rdy", 32'(ready), 0);
        cyc();
        sel = 1'b1;
        idle_chk("xfer desel end");

        // Master 1, 16-beat write at 0x100
        nonseq(32'h100, 1'b1, 3'b110, 1'b1, 1'b0, "m1 16");
        for (int i = 0; i < 8; i++) wbeat(32'h1000 + 32'(i), "m1 16 a");
`ifdef SB_SLAVE_SPLIT_EN
        trans = 2'd0;
        #1;
        chk("spl1 rdy", 32'(ready), 0);
        chk("spl1 resp", 32'(resp), 3);
        cyc();
        #1;
        chk("spl2 rdy", 32'(ready), 1);
        chk("spl2 resp", 32'(resp), 3);
        cyc();
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("release +%0d", k), 32'(split), (k == 4) ? 32'd2 : 32'd0);
            cyc();
        end
        nonseq(32'h108, 1'b1, 3'b110, 1'b1, 1'b0, "m1 resume");
`endif
        for (int i = 8; i < 16; i++) wbeat(32'h1000 + 32'(i), "m1 16 b");
        idle_chk("m1 16 done");
        rburst(32'h100, 3'b101, 8, 32'h1000, "m1 rd lo");
        rburst(32'h108, 3'b101, 8, 32'h1008, "m1 rd hi");

        // Locked 16-beat burst: never split
        wburst(32'h200, 3'b110, 16, 32'h2000, 1'b1, 1'b1, "locked");
        chk("locked split", 32'(split), 0);
        rburst(32'h208, 3'b101, 8, 32'h2008, "locked rd");

        // Address errors leave memory unchanged
        wburst(32'h000, 3'b000, 1, 32'hA5A5A5A5, 1'b0, 1'b0, "pre 000");
        err_seq(32'h800, 3'b000, "err upper");
        rburst(32'h000, 3'b000, 1, 32'hA5A5A5A5, "err upper rd");
        wburst(32'h7FC, 3'b000, 1, 32'h5A5A5A5A, 1'b0, 1'b0, "pre 7fc");
        err_seq(32'h7FC, 3'b101, "err wrap");
        rburst(32'h7FC, 3'b000, 1, 32'h5A5A5A5A, "err wrap rd");
        // Exactly reaching the top is legal
        wburst(32'h7FC, 3'b100, 4, 32'h70, 1'b0, 1'b0, "top wr");
        rburst(32'h7FC, 3'b100, 4, 32'h70, "top rd");

        // Held context and pending release are wiped by reset
        nonseq(32'h400, 1'b1, 3'b110, 1'b0, 1'b0, "m0 16");
        for (int i = 0; i < 8; i++) wbeat(32'h4000 + 32'(i), "m0 16");
`ifdef SB_SLAVE_SPLIT_EN
        trans = 2'd0;
        cyc();
        cyc();
`else
        for (int i = 8; i < 16; i++) wbeat(32'h4000 + 32'(i), "m0 16");
        trans = 2'd0;
`endif
        rst = 1'b1;
        cyc();
        #1;
        chk("ctx rst rdata", rdata, 0);
        chk("ctx rst split", 32'(split), 0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("no release %0d", k), 32'(split), 0);
            cyc();
        end
        // Fresh 4-beat at 0x408: a stale context would have stretched it to 8
        wburst(32'h408, 3'b100, 4, 32'h4408, 1'b0, 1'b0, "fresh 408");

        // Reset at beat 3 of an 8-beat write
        wburst(32'h300, 3'b101, 8, 32'hC0, 1'b1, 1'b0, "pre 300");
        nonseq(32'h300, 1'b1, 3'b101, 1'b1, 1'b0, "rst burst");
        wbeat(32'hE0, "rst burst");
        wbeat(32'hE1, "rst burst");
        trans = 2'd3; wdata = 32'hE2; rst = 1'b1;
        #1;
        chk("rst burst rdy", 32'(ready), 0);
        chk("rst burst resp", 32'(resp), 0);
        cyc();
        rst = 1'b0; trans = 2'd3; wdata = 32'hE3;
        #1;
        chk("rst burst after rdy", 32'(ready), 1);
        chk("rst burst after resp", 32'(resp), 0);
        cyc();
        rburst(32'h300, 3'b011, 2, 32'hE0, "rst rd head");
        rburst(32'h303, 3'b000, 1, 32'hC3, "rst rd 303");
        rburst(32'h304, 3'b100, 4, 32'hC4, "rst rd tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
